in_fifo_mc: RTL

//  Multi-endpoint USB 2.0 full-speed IN FIFO, parametrised successor of the single-endpoint IN FIFO.

---
 rtl/usb_in_pkg.sv | 19 +
 rtl/in_fifo_chan.sv | 53 +++++
 rtl/in_fifo_mc.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/usb_in_pkg.sv
// Shared definitions for the multi-endpoint USB IN FIFO: width helper and transaction FSM states.
package usb_in_pkg;

  function automatic int ceil_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_STATUS = 2'd2
  } in_state_e;

endpackage

// File: rtl/in_fifo_chan.sv
// One IN byte queue: write port from the application, committed read pointer advanced on ACK,
// asynchronous read at an externally supplied (speculative) address.
module in_fifo_chan #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 5
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             wr_en_i,
  input  logic [7:0]       wr_data_i,
  input  logic             cmt_en_i,
  input  logic [PTR_W-1:0] cmt_ptr_i,
  input  logic [PTR_W-2:0] rd_addr_i,
  output logic [7:0]       rd_data_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] cmt_ptr_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam logic [PTR_W-1:0] DEPTH_L = PTR_W'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] cmt_ptr;
  logic [PTR_W-1:0] level;
  logic             wr_fire;

  // Un-ACKed bytes still count toward the level, so space is freed only on commit.
  assign level   = wr_ptr - cmt_ptr;
  assign empty_o = (level == '0);
  assign full_o  = (level == DEPTH_L);
  assign wr_fire = wr_en_i & ~full_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr  <= '0;
      cmt_ptr <= '0;
    end else begin
      if (wr_fire)  wr_ptr  <= wr_ptr + 1'b1;
      if (cmt_en_i) cmt_ptr <= cmt_ptr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[wr_ptr[PTR_W-2:0]] <= wr_data_i;
  end

  assign rd_data_o = mem[rd_addr_i];
  assign wr_ptr_o  = wr_ptr;
  assign cmt_ptr_o = cmt_ptr;

endmodule

// File: rtl/in_fifo_mc.sv
// Multi-endpoint USB full-speed IN FIFO: per-endpoint queues drained one packet per IN
// transaction, with bytes released on host ACK and rolled back on retry.
module in_fifo_mc
  import usb_in_pkg::*;
#(
  parameter int IN_CHANNELS      = 2,
  parameter int IN_MAXPACKETSIZE = 8,
  parameter int IN_FIFO_DEPTH    = 16,
  localparam int EP_W = (IN_CHANNELS > 1) ? ceil_log2(IN_CHANNELS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [8*IN_CHANNELS-1:0] app_in_data_i,
  input  logic [IN_CHANNELS-1:0]   app_in_valid_i,
  output logic [IN_CHANNELS-1:0]   app_in_ready_o,
  output logic [IN_CHANNELS-1:0]   in_empty_o,
  output logic [IN_CHANNELS-1:0]   in_full_o,
  input  logic [EP_W-1:0]          in_endp_i,
  input  logic                     in_req_i,
  output logic [7:0]               in_data_o,
  output logic                     in_valid_o,
  input  logic                     in_ready_i,
  input  logic                     in_data_ack_i,
  output in_state_e                state_o
);

  // Handshake: a byte moves to the SIE on a cycle where in_valid_o and in_ready_i are both
  // high; the application side moves a byte when app_in_valid_i[c] and app_in_ready_o[c] are high.

  localparam int PTR_W = ceil_log2(IN_FIFO_DEPTH) + 1;
  localparam int AW    = PTR_W - 1;
  localparam int NEP   = 1 << EP_W;
  localparam int CNT_W = ceil_log2(IN_MAXPACKETSIZE + 1);

  localparam logic [EP_W:0]    EP_LIM = (EP_W + 1)'(IN_CHANNELS);
  localparam logic [CNT_W-1:0] MAXP_L = CNT_W'(IN_MAXPACKETSIZE);

  in_state_e        state, state_d;
  logic             in_req_q;
  logic             req_rise, req_fall;
  logic             load;
  logic             ack_commit;
  logic [EP_W-1:0]  ep;
  logic [PTR_W-1:0] spec;
  logic [CNT_W-1:0] cnt;
  logic             ep_ok;
  logic             rd_fire;

  logic [PTR_W-1:0] wr_a  [NEP];
  logic [PTR_W-1:0] cmt_a [NEP];
  logic [7:0]       rd_a  [NEP];

  assign req_rise   = in_req_i & ~in_req_q;
  assign req_fall   = ~in_req_i & in_req_q;
  assign ack_commit = (state == ST_STATUS) & in_data_ack_i;
  assign ep_ok      = ({1'b0, ep} < EP_LIM);

  // Table slots beyond IN_CHANNELS read as an empty queue; ep_ok also masks them.
  for (genvar c = 0; c < NEP; c++) begin : g_chan
    if (c < IN_CHANNELS) begin : g_real
      logic cmt_en;
      assign cmt_en = ack_commit & (ep == EP_W'(c));

      in_fifo_chan #(
        .DEPTH (IN_FIFO_DEPTH),
        .PTR_W (PTR_W)
      ) u_chan (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .wr_en_i   (app_in_valid_i[c]),
        .wr_data_i (app_in_data_i[8*c +: 8]),
        .cmt_en_i  (cmt_en),
        .cmt_ptr_i (spec),
        .rd_addr_i (spec[AW-1:0]),
        .rd_data_o (rd_a[c]),
        .wr_ptr_o  (wr_a[c]),
        .cmt_ptr_o (cmt_a[c]),
        .empty_o   (in_empty_o[c]),
        .full_o    (in_full_o[c])
      );

      assign app_in_ready_o[c] = ~in_full_o[c];
    end else begin : g_pad
      assign rd_a[c]  = '0;
      assign wr_a[c]  = '0;
      assign cmt_a[c] = '0;
    end
  end

  assign in_valid_o = (state == ST_DATA) & ep_ok & (spec != wr_a[ep]) & (cnt < MAXP_L);
  assign in_data_o  = in_valid_o ? rd_a[ep] : 8'h00;
  assign rd_fire    = in_valid_o & in_ready_i;
  assign state_o    = state;

  always_comb begin
    state_d = state;
    load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_rise) begin
          state_d = ST_DATA;
          load    = 1'b1;
        end
      end
      ST_DATA: begin
        if (req_fall) state_d = ST_STATUS;
      end
      ST_STATUS: begin
        // A new token without an ACK is a retry: reload from the committed pointer.
        if (in_data_ack_i) begin
          state_d = ST_IDLE;
        end else if (req_rise) begin
          state_d = ST_DATA;
          load    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= ST_IDLE;
      in_req_q <= 1'b0;
    end else begin
      state    <= state_d;
      in_req_q <= in_req_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ep   <= '0;
      spec <= '0;
      cnt  <= '0;
    end else if (load) begin
      ep   <= in_endp_i;
      spec <= cmt_a[in_endp_i];
      cnt  <= '0;
    end else if (rd_fire) begin
      spec <= spec + 1'b1;
      cnt  <= cnt + 1'b1;
    end
  end

endmodule
